// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = host byte source / instruction ROM side.
interface instr_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         mem_we;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: parses count/words/checksum byte stream, writes 9-bit words to
// instruction memory, then starts the processor and waits for it to finish.
module instr_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_go,
    instr_loader_if.master bus,
    output logic          start,
    input  logic          cpu_done,
    output logic          busy,
    output logic          loaded,
    output logic          err,
    output logic [D-1:0]  words_loaded
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CNT_LO = 4'd1;
    localparam logic [3:0] S_CNT_HI = 4'd2;
    localparam logic [3:0] S_W_LO   = 4'd3;
    localparam logic [3:0] S_W_HI   = 4'd4;
    localparam logic [3:0] S_CHK    = 4'd5;
    localparam logic [3:0] S_START  = 4'd6;
    localparam logic [3:0] S_RUN    = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;
    localparam logic [3:0] S_ERR    = 4'd9;

    logic [3:0]   state;
    logic [7:0]   acc;
    logic [7:0]   lo_byte;
    logic [D-1:0] cnt;
    logic         xfer;

    always_comb begin
        bus.in_ready = 1'b0;
        case (state)
            S_CNT_LO, S_CNT_HI, S_W_LO, S_W_HI, S_CHK: bus.in_ready = 1'b1;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign xfer   = bus.in_valid & bus.in_ready;
    assign start  = (state == S_START);
    assign loaded = (state == S_FIN);
    assign err    = (state == S_ERR);
    assign busy   = !(state == S_IDLE || state == S_FIN || state == S_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            lo_byte       <= '0;
            cnt           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            words_loaded  <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            // Address/count advance once the write cycle has been presented.
            if (bus.mem_we) begin
                bus.mem_addr <= bus.mem_addr + D'(1);
                words_loaded <= words_loaded + D'(1);
            end
            if (xfer && state != S_CHK)
                acc <= acc ^ bus.in_data;

            case (state)
                S_IDLE, S_FIN, S_ERR: begin
                    if (load_go) begin
                        state        <= S_CNT_LO;
                        acc          <= '0;
                        words_loaded <= '0;
                        bus.mem_addr <= '0;
                    end
                end
                S_CNT_LO: if (xfer) begin
                    lo_byte <= bus.in_data;
                    state   <= S_CNT_HI;
                end
                S_CNT_HI: if (xfer) begin
                    cnt <= D'({bus.in_data[3:0], lo_byte});
                    if (bus.in_data[7:4] != 4'd0)
                        state <= S_ERR;
                    else if ({bus.in_data[3:0], lo_byte} == 12'd0)
                        state <= S_CHK;
                    else
                        state <= S_W_LO;
                end
                S_W_LO: if (xfer) begin
                    lo_byte <= bus.in_data;
                    state   <= S_W_HI;
                end
                S_W_HI: if (xfer) begin
                    if (bus.in_data[7:1] != 7'd0) begin
                        state <= S_ERR;
                    end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= W'({bus.in_data[0], lo_byte});
                        // words_loaded is already current: a HI byte never shares a cycle with mem_we.
                        state <= (words_loaded + D'(1) == cnt) ? S_CHK : S_W_LO;
                    end
                end
                S_CHK: if (xfer)
                    state <= (bus.in_data == acc) ? S_START : S_ERR;
                S_START: state <= S_RUN;
                S_RUN:   if (cpu_done) state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a stream-parsing model predicts writes, byte
// consumption and outcome; a negedge monitor checks every write against it.
module tb_instr_loader;
    localparam int D = 12;
    localparam int W = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_go = 1'b0;
    logic cpu_done = 1'b0;
    logic start, busy, loaded, err;
    logic [D-1:0] words_loaded;

    instr_loader_if #(.D(D), .W(W)) bus ();

    instr_loader #(.D(D), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_go      (load_go),
        .bus          (bus),
        .start        (start),
        .cpu_done     (cpu_done),
        .busy         (busy),
        .loaded       (loaded),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Model state: expected writes {addr, data}, outcome, bytes the DUT should take.
    logic [7:0]       stream[$];
    logic [D+W-1:0]   exp_wr[$];
    bit               exp_ok;
    bit               exp_full;
    int               exp_words;
    int               exp_consumed;

    task automatic model();
        logic [7:0] x, lo, hi;
        int p, n;
        exp_wr.delete();
        exp_ok = 0; exp_full = 0; exp_words = 0; x = 8'h00;
        if (stream.size() < 2) begin exp_consumed = stream.size(); return; end
        lo = stream[0]; hi = stream[1];
        x = lo ^ hi; p = 2;
        if (hi[7:4] != 4'd0) begin exp_consumed = 2; return; end
        n = int'(hi[3:0]) * 256 + int'(lo);
        for (int i = 0; i < n; i++) begin
            if (p + 2 > stream.size()) begin exp_consumed = stream.size(); return; end
            lo = stream[p]; hi = stream[p+1];
            x = x ^ lo ^ hi;
            if (hi[7:1] != 7'd0) begin exp_consumed = p + 2; return; end
            exp_wr.push_back({D'(i), hi[0], lo});
            exp_words++;
            p += 2;
        end
        if (p >= stream.size()) begin exp_consumed = p; return; end
        exp_consumed = p + 1;
        exp_full = 1;
        exp_ok = (stream[p] == x);
    endtask

    int start_cnt = 0;
    logic [W-1:0] log_d[$];
    logic [D-1:0] log_a[$];

    always @(negedge clk) begin
        logic [D+W-1:0] e;
        if (bus.mem_we === 1'b1) begin
            log_a.push_back(bus.mem_addr);
            log_d.push_back(bus.mem_wdata);
            chk("write_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                chk("write_addr", bus.mem_addr, e[D+W-1:W]);
                chk("write_data", bus.mem_wdata, e[W-1:0]);
            end
        end
        if (start === 1'b1) start_cnt++;
        if (err === 1'b1 || loaded === 1'b1) chk("ready_when_stopped", bus.in_ready, 0);
    end

    task automatic go();
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken (or timed out).
    task automatic send(input logic [7:0] b, input int gap, output bit ok);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        if (!ok) bus.in_valid = 1'b0;
        else @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input int gapmax);
        bit ok;
        int acc, n;
        model();
        start_cnt = 0;
        log_a.delete(); log_d.delete();
        go();
        chk("busy_after_go", busy, 1);
        chk("err_cleared", err, 0);
        chk("loaded_cleared", loaded, 0);
        acc = 0;
        for (int i = 0; i < stream.size(); i++) begin
            send(stream[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, ok);
            if (!ok) break;
            acc++;
        end
        chk("bytes_accepted", acc, exp_consumed);
        if (exp_ok) begin
            n = 0;
            while (start_cnt == 0 && n < 10) begin @(negedge clk); n++; end
            chk("start_seen", start_cnt, 1);
            repeat (5) @(negedge clk);
            chk("loaded_before_done", loaded, 0);
            cpu_done = 1'b1;
            n = 0;
            while (loaded !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            cpu_done = 1'b0;
            chk("loaded", loaded, 1);
            chk("busy_fin", busy, 0);
            chk("err_fin", err, 0);
            chk("start_once", start_cnt, 1);
        end else begin
            repeat (4) @(negedge clk);
            chk("err_set", err, 1);
            chk("loaded_err", loaded, 0);
            chk("busy_err", busy, 0);
            chk("no_start", start_cnt, 0);
        end
        chk("words_loaded", words_loaded, exp_words);
        chk("writes_all_seen", exp_wr.size(), 0);
    endtask

    task automatic set3(input logic [7:0] c);
        stream = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01, c};
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        logic [D+W-1:0] e;
        logic [W-1:0] d;
        bit ok;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the model against hand-computed values for the 3-word image.
        set3(8'hDA);
        model();
        chk("model_nwr", exp_wr.size(), 3);
        e = exp_wr[0]; chk("model_w0", e, {12'd0, 9'h112});
        e = exp_wr[1]; chk("model_w1", e, {12'd1, 9'h034});
        e = exp_wr[2]; chk("model_w2", e, {12'd2, 9'h1FF});
        chk("model_ok", exp_ok, 1);
        chk("model_consumed", exp_consumed, 9);

        // 3-word load, then literal check of the logged writes.
        run(0);
        chk("log_n", log_d.size(), 3);
        if (log_d.size() == 3) begin
            d = log_d[0]; chk("lit_d0", d, 9'h112);
            d = log_d[1]; chk("lit_d1", d, 9'h034);
            d = log_d[2]; chk("lit_d2", d, 9'h1FF);
            chk("lit_a2", log_a[2], 12'd2);
        end
        chk("lit_words", words_loaded, 3);

        // Zero-length image.
        stream = '{8'h00, 8'h00, 8'h00};
        run(0);
        chk("zero_no_writes", log_d.size(), 0);

        // Bad checksum: writes land, then ERR; restart recovers.
        set3(8'hDB);
        run(0);
        chk("badchk_writes", log_d.size(), 3);
        set3(8'hDA);
        run(0);

        // Illegal count high nibble.
        stream = '{8'h05, 8'h10, 8'h12, 8'h01};
        run(0);
        chk("cnthi_no_writes", log_d.size(), 0);

        // Illegal HI byte in second word.
        stream = '{8'h02, 8'h00, 8'h12, 8'h01, 8'h34, 8'h02, 8'h00};
        run(0);
        chk("badhi_one_write", log_d.size(), 1);

        // Backpressure with random gaps.
        set3(8'hDA);
        run(4);
        chk("gap_writes", log_d.size(), 3);
        set3(8'hDB);
        run(4);

        // Reset right after the 2nd word's HI byte.
        stream = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00};
        model();
        start_cnt = 0;
        go();
        for (int i = 0; i < stream.size(); i++) send(stream[i], 0, ok);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        chk("midrst_writes_seen", exp_wr.size(), 0);
        chk("midrst_no_start", start_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_start_after", start_cnt, 0);
        set3(8'hDA);
        run(0);
        if (log_a.size() > 0) chk("after_rst_addr0", log_a[0], 12'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end
endmodule
